// File: rtl/xor_share_arb_pkg.sv
// Shared definitions for the two-requester XOR arbiter: FSM encoding,
// requester index constants and the default operand width.
package xor_share_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/xor_share_arb_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter. Purely combinational; the caller
// owns the priority pointer and decides when to advance it.
module rr_arb2
  import xor_share_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // On a tie the pointer names the favoured requester.
        2'b11:   grant = (ptr == REQ1) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/xor_share_arb.sv
// Two requesters share one registered XOR unit behind a round-robin arbiter
// and a one-entry output register. Optional z_par output: XOR_SHARE_ARB_PARITY_EN.
module xor_share_arb
  import xor_share_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic [WIDTH-1:0] z,
  output logic             z_id,
`ifdef XOR_SHARE_ARB_PARITY_EN
  output logic             z_par,
`endif
  output logic             z_valid,
  input  logic             z_ready
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_ptr;
  logic [WIDTH-1:0] r_z;
  logic             r_z_id;

  logic             w_accept;
  logic             w_enable;
  logic [1:0]       w_grant;
  logic             w_any_gnt;
  logic             w_gnt_id;
  logic [WIDTH-1:0] w_z_next;

  // The output slot can take a new result when empty or being drained now.
  assign w_accept  = (r_state == EMPTY) || z_ready;
  assign w_enable  = w_accept && !rst;
  assign w_any_gnt = |w_grant;
  assign w_gnt_id  = w_grant[1] ? REQ1 : REQ0;
  assign w_z_next  = w_grant[1] ? (a1 ^ b1) : (a0 ^ b0);

  rr_arb2 u_arb (
    .req    ({req1, req0}),
    .enable (w_enable),
    .ptr    (r_ptr),
    .grant  (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      EMPTY: if (w_any_gnt) w_state_next = FULL;
      FULL: begin
        if (w_any_gnt)    w_state_next = FULL;
        else if (z_ready) w_state_next = EMPTY;
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Result and pointer only move on a grant; a drain alone leaves z/z_id intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= REQ0;
      r_z    <= '0;
      r_z_id <= REQ0;
    end else if (w_any_gnt) begin
      r_ptr  <= ~w_gnt_id;
      r_z    <= w_z_next;
      r_z_id <= w_gnt_id;
    end
  end

`ifdef XOR_SHARE_ARB_PARITY_EN
  logic r_z_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_z_par <= 1'b0;
    end else if (w_any_gnt) begin
      r_z_par <= ^w_z_next;
    end
  end

  assign z_par = r_z_par;
`endif

  assign gnt0    = w_grant[0];
  assign gnt1    = w_grant[1];
  assign z       = r_z;
  assign z_id    = r_z_id;
  assign z_valid = (r_state == FULL);

endmodule

// File: tb/tb_xor_share_arb.sv
// Bench for xor_share_arb: directed scenarios followed by constrained-random
// traffic, all checked against a transaction-level model of the arbiter.
module tb_xor_share_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] a0 = '0;
  logic [W-1:0] b0 = '0;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] b1 = '0;
  logic         z_ready = 1'b0;
  logic         gnt0;
  logic         gnt1;
  logic [W-1:0] z;
  logic         z_id;
  logic         z_valid;
`ifdef XOR_SHARE_ARB_PARITY_EN
  logic         z_par;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: is a result held, who is favoured on a tie, what is held.
  bit           m_valid = 1'b0;
  bit           m_ptr   = 1'b0;
  bit           m_id    = 1'b0;
  logic [W-1:0] m_z     = '0;
  bit           e_g0    = 1'b0;
  bit           e_g1    = 1'b0;

  xor_share_arb #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .gnt0    (gnt0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .gnt1    (gnt1),
    .z       (z),
    .z_id    (z_id),
`ifdef XOR_SHARE_ARB_PARITY_EN
    .z_par   (z_par),
`endif
    .z_valid (z_valid),
    .z_ready (z_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Who should win this cycle, from the rules: slot free or draining, no reset,
  // single requester wins outright, tie goes to the favoured one.
  task automatic predict_grant();
    bit can_take;
    can_take = !m_valid || z_ready;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!rst && can_take) begin
      if (req0 && req1) begin
        if (m_ptr) e_g1 = 1'b1;
        else       e_g0 = 1'b1;
      end else if (req0) begin
        e_g0 = 1'b1;
      end else if (req1) begin
        e_g1 = 1'b1;
      end
    end
  endtask

  // One clock cycle: inputs already driven in the low phase.
  task automatic step(input string tag);
    #1;
    predict_grant();
    chk({tag, ".gnt0"}, {31'd0, gnt0}, {31'd0, e_g0});
    chk({tag, ".gnt1"}, {31'd0, gnt1}, {31'd0, e_g1});
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 1'b0;
      m_id    = 1'b0;
      m_z     = '0;
    end else if (e_g0 || e_g1) begin
      m_id    = e_g1;
      m_z     = e_g1 ? (a1 ^ b1) : (a0 ^ b0);
      m_valid = 1'b1;
      m_ptr   = !e_g1;
    end else if (m_valid && z_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk({tag, ".z_valid"}, {31'd0, z_valid}, {31'd0, m_valid});
    chk({tag, ".z"}, {24'd0, z}, {24'd0, m_z});
    chk({tag, ".z_id"}, {31'd0, z_id}, {31'd0, m_id});
`ifdef XOR_SHARE_ARB_PARITY_EN
    chk({tag, ".z_par"}, {31'd0, z_par}, {31'd0, ^m_z});
`endif
    $display("step %-6s rst=%b req=%b%b rdy=%b gnt=%b%b z=%h id=%b v=%b",
             tag, rst, req1, req0, z_ready, gnt1, gnt0, z, z_id, z_valid);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);

    // Reset with requests pending: no grant, everything cleared.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; z_ready = 1'b1;
    step("reset");
    chk("reset.z_valid", {31'd0, z_valid}, 32'd0);
    chk("reset.z", {24'd0, z}, 32'd0);

    // Single grant, one-cycle latency.
    rst = 1'b0; req0 = 1'b1; req1 = 1'b0; a0 = 8'hA5; b0 = 8'h0F; z_ready = 1'b1;
    step("r031");
    chk("r031.z", {24'd0, z}, 32'hAA);
    chk("r031.z_id", {31'd0, z_id}, 32'd0);
    chk("r031.z_valid", {31'd0, z_valid}, 32'd1);

    // No further requests: result drains, value retained.
    req0 = 1'b0;
    step("r035");
    chk("r035.z_valid", {31'd0, z_valid}, 32'd0);
    chk("r035.z", {24'd0, z}, 32'hAA);

    // Fresh reset, then a persistent tie alternates 0,1,0,1.
    rst = 1'b1;
    step("rst2");
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h11; b0 = 8'h00; a1 = 8'h22; b1 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step("r032");
      chk("r032.z", {24'd0, z}, (i % 2 == 1) ? 32'h22 : 32'h11);
      chk("r032.z_id", {31'd0, z_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end

    // Backpressure freezes everything; release resumes with requester 0.
    z_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("r033s");
      chk("r033.z", {24'd0, z}, 32'h22);
      chk("r033.z_id", {31'd0, z_id}, 32'd1);
    end
    z_ready = 1'b1;
    step("r033r");
    chk("r033r.z_id", {31'd0, z_id}, 32'd0);
    chk("r033r.z", {24'd0, z}, 32'h11);

    // Grant to requester 1, reset discards it, tie then favours 0.
    req0 = 1'b0; req1 = 1'b1; a1 = 8'h3C; b1 = 8'h00;
    step("r034g");
    chk("r034.z", {24'd0, z}, 32'h3C);
    chk("r034.z_id", {31'd0, z_id}, 32'd1);
    rst = 1'b1; req0 = 1'b1;
    step("r034r");
    chk("r034r.z_valid", {31'd0, z_valid}, 32'd0);
    chk("r034r.z", {24'd0, z}, 32'd0);
    rst = 1'b0;
    step("r034t");
    chk("r034t.z_id", {31'd0, z_id}, 32'd0);
    chk("r034t.z", {24'd0, z}, 32'h11);

`ifdef XOR_SHARE_ARB_PARITY_EN
    req1 = 1'b0; req0 = 1'b1; a0 = 8'h07; b0 = 8'h00;
    step("r036a");
    chk("r036a.z_par", {31'd0, z_par}, 32'd1);
    a0 = 8'h03;
    step("r036b");
    chk("r036b.z_par", {31'd0, z_par}, 32'd0);
`endif

    // Random traffic: a requester holds its request until granted.
    for (int i = 0; i < 400; i++) begin
      if (e_g0 || !req0) begin
        req0 = ($urandom_range(0, 3) != 0);
        a0   = W'($urandom);
        b0   = W'($urandom);
      end
      if (e_g1 || !req1) begin
        req1 = ($urandom_range(0, 3) != 0);
        a1   = W'($urandom);
        b1   = W'($urandom);
      end
      z_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 49) == 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_share_arb.md
XOR_SHARE_ARB -- requirements
Module: xor_share_arb

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (1..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 holds operands valid.
REQ-005 a0, b0  input  WIDTH  requester 0 operands.
REQ-006 gnt0  output  1  requester 0 operands consumed this edge (combinational).
REQ-007 req1, a1, b1, gnt1: same as REQ-004..006, for requester 1.
REQ-008 z  output  WIDTH  registered result a^b of the granted requester.
REQ-009 z_id  output  1  requester index that produced z.
REQ-010 z_valid  output  1  z/z_id hold a result not yet accepted.
REQ-011 z_ready  input  1  downstream accepts z when z_valid && z_ready at an edge.

Function
REQ-012 Output-register FSM, two states: EMPTY (z_valid=0), FULL (z_valid=1).
REQ-013 accept = (state==EMPTY) || z_ready; no grant when accept=0.
REQ-014 Exactly one of req0/req1 high with accept=1: that requester is granted.
REQ-015 Both high with accept=1: grant the requester selected by priority pointer ptr (0 or 1).
REQ-016 After every grant, ptr <= index of the requester not granted; ptr unchanged when nothing is granted.
REQ-017 gnt0/gnt1 are mutually exclusive, never high without the matching req, and 0 while rst=1.
REQ-018 On a grant edge: z <= a_k ^ b_k, z_id <= k, state -> FULL; latency 1 cycle from grant to z_valid.
REQ-019 FULL with z_ready=1 and a grant in the same cycle: stays FULL, new result replaces old (back-to-back, 1 result/cycle).
REQ-020 FULL with z_ready=1 and no grant: -> EMPTY; z and z_id keep their last value.
REQ-021 FULL with z_ready=0: z, z_id, z_valid, ptr all held; both gnt low.
REQ-022 Requester keeps req and operands stable until it sees gnt; operands may change in the cycle after gnt.
REQ-023 z_ready is ignored in EMPTY.

Reset
REQ-024 rst=1 at an edge: state=EMPTY, z_valid=0, z=0, z_id=0, ptr=0, regardless of state or pending requests.
REQ-025 A result pending at reset is discarded; no grant is issued in a cycle where rst=1.
REQ-026 First arbitration after reset favours requester 0 on a tie.

Configuration
REQ-027 Macro XOR_SHARE_ARB_PARITY_EN defined: extra output z_par (1 bit), registered with z, equal to reduction XOR of the new z, reset 0, held under the same rules as z.
REQ-028 Macro undefined: z_par port absent; all other behaviour identical.

Structure
REQ-029 Shared package xor_share_arb_pkg holds FSM state encoding (EMPTY=0, FULL=1), requester index constants (REQ0=0, REQ1=1) and the WIDTH default.
REQ-030 Sub-module rr_arb2: 2-input round-robin arbiter (inputs req[1:0], enable, ptr; outputs one-hot grant); ptr register stays in xor_share_arb.

Verification
REQ-031 Reset, then req0=1, a0=8'hA5, b0=8'h0F, z_ready=1 -> gnt0 same cycle, next cycle z=8'hAA, z_id=0, z_valid=1.
REQ-032 Both req held 4 cycles with z_ready=1, a0^b0=8'h11, a1^b1=8'h22 -> grants alternate 0,1,0,1; z sequence 11,22,11,22.
REQ-033 z_ready=0 with z_valid=1 and both req high for 3 cycles -> no gnt, z/z_id/ptr stable; raise z_ready -> grant resumes with next round-robin requester.
REQ-034 Grant to req1 (z=8'h3C), then rst pulsed one cycle -> z_valid=0, z=0, ptr=0; tie afterwards grants requester 0.
REQ-035 Single result, no further req, z_ready=1 -> z_valid drops after one cycle, z retains value.
REQ-036 With XOR_SHARE_ARB_PARITY_EN, a0=8'h07, b0=8'h00 -> z=8'h07, z_par=1; a0=8'h03 -> z_par=0.
